// File: rtl/pht_pkg.sv
// rtl/pht_pkg.sv - shared types and limits for the pattern history table
package pht_pkg;

  typedef enum logic {
    PHT_INIT  = 1'b0,
    PHT_READY = 1'b1
  } pht_state_t;

  localparam int PHT_MAX_CNT_WIDTH = 4;

endpackage

// File: rtl/pht_sat_counter.sv
// rtl/pht_sat_counter.sv - combinational saturating up/down step for one counter
module pht_sat_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] cur_i,
  input  logic                 taken_i,
  output logic [CNT_WIDTH-1:0] next_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = {CNT_WIDTH{1'b1}};

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != MAX_CNT) next_o = cur_i + CNT_WIDTH'(1);
    end else begin
      if (cur_i != '0) next_o = cur_i - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pht_counter_table.sv
// rtl/pht_counter_table.sv - PHT with predict/resolve read ports, self update and init sweep
// Optional feature: define PHT_BYPASS_EN for write-through forwarding on both read ports.
module pht_counter_table
  import pht_pkg::*;
#(
  parameter int S_INDEX   = 5,
  parameter int CNT_WIDTH = 2,
  parameter int INIT_VAL  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic                 ready,
  input  logic [S_INDEX-1:0]   bp_index,
  output logic [CNT_WIDTH-1:0] bp_count,
  output logic                 pred_taken,
  input  logic [S_INDEX-1:0]   rd_index,
  output logic [CNT_WIDTH-1:0] rd_count,
  input  logic                 upd_valid,
  input  logic [S_INDEX-1:0]   upd_index,
  input  logic                 upd_taken
);

  localparam int                   NUM_SETS = 1 << S_INDEX;
  localparam logic [CNT_WIDTH-1:0] INIT_CNT = CNT_WIDTH'(INIT_VAL);
  localparam logic [S_INDEX-1:0]   LAST_PTR = {S_INDEX{1'b1}};

  pht_state_t         state_q, state_d;
  logic [S_INDEX-1:0] sweep_ptr_q, sweep_ptr_d;

  (* ramstyle = "logic" *) logic [CNT_WIDTH-1:0] data_q [NUM_SETS];

  logic                 wr_en;
  logic [S_INDEX-1:0]   wr_idx;
  logic [CNT_WIDTH-1:0] wr_data;
  logic [CNT_WIDTH-1:0] upd_cur, upd_next;
  logic [CNT_WIDTH-1:0] bp_raw, rd_raw;
  logic                 upd_live;

  assign ready    = (state_q == PHT_READY);
  assign upd_live = upd_valid && ready;
  assign upd_cur  = data_q[upd_index];

  // Single counter step shared by the array write and the forwarding path.
  pht_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat (
    .cur_i   (upd_cur),
    .taken_i (upd_taken),
    .next_o  (upd_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PHT_INIT;
      sweep_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    wr_en       = 1'b0;
    wr_idx      = upd_index;
    wr_data     = upd_next;
    case (state_q)
      PHT_INIT: begin
        wr_en       = 1'b1;
        wr_idx      = sweep_ptr_q;
        wr_data     = INIT_CNT;
        sweep_ptr_d = sweep_ptr_q + S_INDEX'(1);
        if (sweep_ptr_q == LAST_PTR) state_d = PHT_READY;
        if (flush) begin
          state_d     = PHT_INIT;
          sweep_ptr_d = '0;
        end
      end
      PHT_READY: begin
        if (flush) begin
          state_d     = PHT_INIT;
          sweep_ptr_d = '0;
        end else if (upd_valid) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        state_d     = PHT_INIT;
        sweep_ptr_d = '0;
      end
    endcase
  end

  // Contents are not reset; the sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx] <= wr_data;
  end

`ifdef PHT_BYPASS_EN
  assign bp_raw = (upd_live && (bp_index == upd_index)) ? upd_next : data_q[bp_index];
  assign rd_raw = (upd_live && (rd_index == upd_index)) ? upd_next : data_q[rd_index];
`else
  assign bp_raw = data_q[bp_index];
  assign rd_raw = data_q[rd_index];
`endif

  assign bp_count   = ready ? bp_raw : INIT_CNT;
  assign rd_count   = ready ? rd_raw : INIT_CNT;
  assign pred_taken = bp_count[CNT_WIDTH-1];

endmodule

// File: tb/tb_pht_counter_table.sv
// tb/tb_pht_counter_table.sv - directed self-checking bench for pht_counter_table
module tb_pht_counter_table;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       ready;
  logic [4:0] bp_index, rd_index, upd_index;
  logic [1:0] bp_count, rd_count;
  logic       pred_taken;
  logic       upd_valid, upd_taken;

  logic       rst3_n;
  logic       ready3;
  logic [4:0] bp3_index, rd3_index, upd3_index;
  logic [2:0] bp3_count, rd3_count;
  logic       pred3_taken;
  logic       upd3_valid, upd3_taken;

  int n_cmp;
  int n_err;

  pht_counter_table #(.S_INDEX(5), .CNT_WIDTH(2), .INIT_VAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready),
    .bp_index(bp_index), .bp_count(bp_count), .pred_taken(pred_taken),
    .rd_index(rd_index), .rd_count(rd_count),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken)
  );

  pht_counter_table #(.S_INDEX(5), .CNT_WIDTH(3), .INIT_VAL(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .flush(1'b0), .ready(ready3),
    .bp_index(bp3_index), .bp_count(bp3_count), .pred_taken(pred3_taken),
    .rd_index(rd3_index), .rd_count(rd3_count),
    .upd_valid(upd3_valid), .upd_index(upd3_index), .upd_taken(upd3_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with ready low, starting with the current one; optionally pulses upd_valid.
  task automatic wait_ready(input string tag, input bit pulse_upd);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      if (ready) break;
      if (pulse_upd) upd_valid = ~zeros[0];
      zeros++;
      tick();
    end
    upd_valid = 1'b0;
    #1;
    chk(tag, zeros, 32);
  endtask

  task automatic update(input logic [4:0] idx, input logic taken);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = taken;
    tick();
    upd_valid = 1'b0;
    #1;
  endtask

  logic [1:0] exp2 [8];
  logic [2:0] e3;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; rst3_n = 1'b0; flush = 1'b0;
    bp_index = '0; rd_index = '0; upd_index = '0; upd_valid = 1'b0; upd_taken = 1'b0;
    bp3_index = '0; rd3_index = '0; upd3_index = '0; upd3_valid = 1'b0; upd3_taken = 1'b0;
    exp2[0] = 2; exp2[1] = 3; exp2[2] = 3; exp2[3] = 3;
    exp2[4] = 2; exp2[5] = 1; exp2[6] = 0; exp2[7] = 0;

    tick();
    tick();
    chk("reset_ready", ready, 0);
    chk("reset_rd_forced", rd_count, 1);
    chk("reset_pred", pred_taken, 0);

    // 1: sweep length after reset release, then every entry at INIT_VAL
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst3_n = 1'b1;
    #1;
    wait_ready("sweep_after_reset", 1'b0);
    chk("ready_high", ready, 1);
    for (int i = 0; i < 32; i++) begin
      rd_index = 5'(i);
      #1;
      chk($sformatf("init_entry_%0d", i), rd_count, 1);
    end

    // 2: saturating increments then decrements at index 7
    rd_index = 5'd7;
    bp_index = 5'd7;
    for (int k = 0; k < 8; k++) begin
      update(5'd7, (k < 4) ? 1'b1 : 1'b0);
      chk($sformatf("idx7_step_%0d", k), rd_count, exp2[k]);
      if (k < 4) chk($sformatf("idx7_pred_%0d", k), pred_taken, 1);
    end
    chk("idx7_pred_final", pred_taken, 0);

    // 3: same-cycle visibility of an update on the predict port
    bp_index = 5'd5;
    rd_index = 5'd5;
    upd_valid = 1'b1;
    upd_index = 5'd5;
    upd_taken = 1'b1;
    #1;
`ifdef PHT_BYPASS_EN
    chk("bypass_bp_same", bp_count, 2);
    chk("bypass_rd_same", rd_count, 2);
`else
    chk("nobypass_bp_same", bp_count, 1);
    chk("nobypass_rd_same", rd_count, 1);
`endif
    tick();
    upd_valid = 1'b0;
    #1;
    chk("idx5_next_cycle", bp_count, 2);
    chk("idx5_pred", pred_taken, 1);

    // 4: flush collides with an update at index 3
    rd_index = 5'd3;
    update(5'd3, 1'b1);
    update(5'd3, 1'b1);
    chk("idx3_before_flush", rd_count, 3);
    flush = 1'b1;
    upd_valid = 1'b1;
    upd_index = 5'd3;
    upd_taken = 1'b0;
    tick();
    flush = 1'b0;
    upd_valid = 1'b0;
    #1;
    chk("flush_ready_low", ready, 0);
    chk("flush_rd_forced", rd_count, 1);
    wait_ready("sweep_after_flush", 1'b0);
    chk("idx3_after_flush", rd_count, 1);
    rd_index = 5'd7;
    #1;
    chk("idx7_after_flush", rd_count, 1);

    // 5: reset mid-sweep at sweep_ptr=10, updates during sweep ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midsweep_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", ready, 0);
    tick();
    rst_n = 1'b1;
    upd_index = 5'd9;
    upd_taken = 1'b1;
    #1;
    wait_ready("sweep_after_midreset", 1'b1);
    rd_index = 5'd9;
    #1;
    chk("idx9_untouched", rd_count, 1);

    // 6: wider counter, INIT_VAL=3 saturating at 7
    chk("w3_ready", ready3, 1);
    rd3_index = 5'd4;
    bp3_index = 5'd4;
    #1;
    chk("w3_init", rd3_count, 3);
    chk("w3_pred_init", pred3_taken, 0);
    e3 = 3'd3;
    for (int k = 0; k < 10; k++) begin
      upd3_valid = 1'b1;
      upd3_index = 5'd4;
      upd3_taken = 1'b1;
      tick();
      upd3_valid = 1'b0;
      #1;
      if (e3 != 3'd7) e3 = e3 + 3'd1;
      chk($sformatf("w3_step_%0d", k), rd3_count, e3);
      if (k == 0) chk("w3_pred_flip", pred3_taken, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
